// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared types and constants for the instruction-memory
// boot loader.
//   state_e    - loader FSM states
//   BCNT_W     - width of the byte-in-word counter
//   CSUM_W     - width of the XOR checksum accumulator
//   LEN_BYTES  - number of bytes in the little-endian length field
package imem_loader_pkg;

    typedef enum logic [2:0] {
        S_LEN,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_e;

    localparam int BCNT_W    = 2;
    localparam int CSUM_W    = 8;
    localparam int LEN_BYTES = 4;

endpackage

// File: rtl/imem_loader_if.sv
// imem_loader_if: byte-stream handshake plus instruction-memory write port.
//   byte_valid/byte_data - byte source -> loader
//   byte_ready           - loader -> byte source
//   imem_we/waddr/wdata  - loader -> instruction memory write port
// modport slave  : the loader
// modport master : the byte source / memory side
interface imem_loader_if;

    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        imem_we;
    logic [29:0] imem_waddr;
    logic [31:0] imem_wdata;

    modport slave (
        input  byte_valid, byte_data,
        output byte_ready, imem_we, imem_waddr, imem_wdata
    );

    modport master (
        output byte_valid, byte_data,
        input  byte_ready, imem_we, imem_waddr, imem_wdata
    );

endinterface

// File: rtl/imem_loader_byte_packer.sv
// imem_loader_byte_packer: 4-byte little-endian shift-in buffer.
//   clk_i, rst_ni  - clock, async active-low reset
//   clear_i        - synchronous clear of counter and buffer
//   valid_i/data_i - byte accepted this cycle
//   word_valid_o   - combinational pulse on the 4th byte of a word
//   word_o         - assembled word, valid while word_valid_o is high
// Only the first three bytes are stored; the fourth is taken straight
// from data_i so the word is usable in the same cycle it completes.
module imem_loader_byte_packer
    import imem_loader_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        clear_i,
    input  logic        valid_i,
    input  logic [7:0]  data_i,
    output logic        word_valid_o,
    output logic [31:0] word_o
);

    logic [BCNT_W-1:0] cnt_q;
    logic [23:0]       buf_q;

    assign word_valid_o = valid_i && (cnt_q == BCNT_W'(LEN_BYTES - 1));
    assign word_o       = {data_i, buf_q};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
            buf_q <= '0;
        end else if (clear_i) begin
            cnt_q <= '0;
            buf_q <= '0;
        end else if (valid_i) begin
            // counter wraps 3 -> 0 naturally at the end of a word
            cnt_q <= cnt_q + 1'b1;
            buf_q <= {data_i, buf_q[23:8]};
        end
    end

endmodule

// File: rtl/imem_loader.sv
// imem_loader: boot-time program loader for the instruction memory.
// Receives <len:4 bytes LE> <len words, LE bytes> <xor checksum byte>,
// writes each word to the memory, and releases the core reset only when
// the image length is legal and the checksum matches.
//   clk_i, rst_ni   - clock, async active-low reset
//   start_i         - re-arm a load from DONE or ERR
//   bus             - byte handshake + memory write port (slave side)
//   core_rst_no     - active-low core reset, high only in DONE
//   done_o, err_o   - load finished cleanly / length or checksum error
//   words_loaded_o  - number of words written so far
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          MAX_WORDS = 1024
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                start_i,
    imem_loader_if.slave        bus,
    output logic                core_rst_no,
    output logic                done_o,
    output logic                err_o,
    output logic [31:0]         words_loaded_o
);

    localparam logic [31:0] MAX_W = 32'(MAX_WORDS);

    state_e            state_q, state_d;
    logic [31:0]       len_q;
    logic [31:0]       words_q;
    logic [CSUM_W-1:0] csum_q;
    logic              we_q;
    logic [29:0]       waddr_q;
    logic [31:0]       wdata_q;
    logic              done_q, err_q;

    logic        ready, accept, restart;
    logic        pk_valid, pk_word_valid;
    logic [31:0] pk_word;
    logic        wr_word;

    assign ready   = (state_q == S_LEN) || (state_q == S_DATA) || (state_q == S_CSUM);
    assign accept  = bus.byte_valid && ready;
    assign restart = start_i && ((state_q == S_DONE) || (state_q == S_ERR));

    // One packer serves both the length field and the data words; its
    // counter is back at 0 when the length completes.
    assign pk_valid = accept && ((state_q == S_LEN) || (state_q == S_DATA));
    assign wr_word  = pk_word_valid && (state_q == S_DATA);

    imem_loader_byte_packer u_packer (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .clear_i      (restart),
        .valid_i      (pk_valid),
        .data_i       (bus.byte_data),
        .word_valid_o (pk_word_valid),
        .word_o       (pk_word)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_LEN: begin
                if (pk_word_valid) begin
                    if (pk_word > MAX_W)      state_d = S_ERR;
                    else if (pk_word == '0)   state_d = S_CSUM;
                    else                      state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (wr_word && (words_q + 32'd1 == len_q)) state_d = S_CSUM;
            end
            S_CSUM: begin
                if (accept) state_d = (bus.byte_data == csum_q) ? S_DONE : S_ERR;
            end
            S_DONE, S_ERR: begin
                if (start_i) state_d = S_LEN;
            end
            default: state_d = S_LEN;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_LEN;
            len_q   <= '0;
            words_q <= '0;
            csum_q  <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= (state_d == S_DONE);
            err_q   <= (state_d == S_ERR);
            we_q    <= wr_word;
            if (restart) begin
                len_q   <= '0;
                words_q <= '0;
                csum_q  <= '0;
            end else begin
                if (pk_word_valid && (state_q == S_LEN)) len_q <= pk_word;
                if (accept && (state_q == S_DATA)) csum_q <= csum_q ^ bus.byte_data;
                if (wr_word) begin
                    // 30-bit add: address wraps silently past the top
                    waddr_q <= BASE_ADDR[31:2] + words_q[29:0];
                    wdata_q <= pk_word;
                    words_q <= words_q + 32'd1;
                end
            end
        end
    end

    assign bus.byte_ready  = ready;
    assign bus.imem_we     = we_q;
    assign bus.imem_waddr  = waddr_q;
    assign bus.imem_wdata  = wdata_q;
    assign core_rst_no     = done_q;
    assign done_o          = done_q;
    assign err_o           = err_q;
    assign words_loaded_o  = words_q;

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic start_w = 1'b0;

    imem_loader_if ifm();
    imem_loader_if ifw();

    logic        crm, donem, errm;
    logic [31:0] wlm;
    logic        crw, donew, errw;
    logic [31:0] wlw;

    imem_loader #(.BASE_ADDR(32'h0000_0000), .MAX_WORDS(1024)) u_dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .bus(ifm.slave),
        .core_rst_no(crm), .done_o(donem), .err_o(errm), .words_loaded_o(wlm)
    );

    imem_loader #(.BASE_ADDR(32'hFFFF_FFFC), .MAX_WORDS(1024)) u_wrap (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start_w), .bus(ifw.slave),
        .core_rst_no(crw), .done_o(donew), .err_o(errw), .words_loaded_o(wlw)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int stalls = 0;

    logic [29:0] qa_m[$];
    logic [31:0] qd_m[$];
    logic [29:0] qa_w[$];
    logic [31:0] qd_w[$];

    always @(negedge clk) begin
        if (ifm.imem_we === 1'b1) begin qa_m.push_back(ifm.imem_waddr); qd_m.push_back(ifm.imem_wdata); end
        if (ifw.imem_we === 1'b1) begin qa_w.push_back(ifw.imem_waddr); qd_w.push_back(ifw.imem_wdata); end
    end

    task automatic send(input bit w, input logic [7:0] b);
        @(negedge clk);
        if (w) begin
            ifw.byte_valid = 1'b1; ifw.byte_data = b;
            if (ifw.byte_ready !== 1'b1) stalls++;
        end else begin
            ifm.byte_valid = 1'b1; ifm.byte_data = b;
            if (ifm.byte_ready !== 1'b1) stalls++;
        end
        @(posedge clk);
    endtask

    task automatic idle();
        @(negedge clk);
        ifm.byte_valid = 1'b0;
        ifw.byte_valid = 1'b0;
    endtask

    // length 2, words 0x00000013 and 0x00100093 (checksum 0x90)
    task automatic send_body(input bit w);
        logic [7:0] img [12];
        img = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                8'h93, 8'h00, 8'h10, 8'h00};
        for (int i = 0; i < 12; i++) send(w, img[i]);
    endtask

    task automatic do_reset();
        @(negedge clk);
        ifm.byte_valid = 1'b0;
        ifw.byte_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        qa_m.delete(); qd_m.delete(); qa_w.delete(); qd_w.delete();
    endtask

    task automatic test_reset();
        #12;
        total++; if (ifm.byte_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", ifm.byte_ready); end
        total++; if (ifm.imem_we !== 1'b0) begin bad++; $display("FAIL reset_we: got %b want 0", ifm.imem_we); end
        total++; if (ifm.imem_waddr !== 30'h0 || ifm.imem_wdata !== 32'h0) begin bad++; $display("FAIL reset_wbus: got %h/%h want 0/0", ifm.imem_waddr, ifm.imem_wdata); end
        total++; if ({crm, donem, errm} !== 3'b000) begin bad++; $display("FAIL reset_flags: got %b want 000", {crm, donem, errm}); end
        total++; if (wlm !== 32'd0) begin bad++; $display("FAIL reset_words: got %0d want 0", wlm); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_load_ok();
        do_reset();
        send_body(1'b0);
        @(negedge clk);
        ifm.byte_valid = 1'b1; ifm.byte_data = 8'h90;
        total++; if (crm !== 1'b0) begin bad++; $display("FAIL ok_corerst_before: got %b want 0", crm); end
        @(posedge clk);
        idle();
        total++; if (crm !== 1'b1 || donem !== 1'b1) begin bad++; $display("FAIL ok_done: got rst_n=%b done=%b want 1/1", crm, donem); end
        total++; if (qa_m.size() != 2) begin bad++; $display("FAIL ok_nwrites: got %0d want 2", qa_m.size()); end
        total++; if (qa_m[0] !== 30'd0 || qd_m[0] !== 32'h0000_0013) begin bad++; $display("FAIL ok_w0: got %h/%h want 0/00000013", qa_m[0], qd_m[0]); end
        total++; if (qa_m[1] !== 30'd1 || qd_m[1] !== 32'h0010_0093) begin bad++; $display("FAIL ok_w1: got %h/%h want 1/00100093", qa_m[1], qd_m[1]); end
        total++; if (wlm !== 32'd2 || ifm.byte_ready !== 1'b0) begin bad++; $display("FAIL ok_words_ready: got %0d/%b want 2/0", wlm, ifm.byte_ready); end
    endtask

    task automatic test_bad_csum();
        do_reset();
        send_body(1'b0);
        send(1'b0, 8'h91);
        idle();
        total++; if (errm !== 1'b1 || donem !== 1'b0) begin bad++; $display("FAIL bad_err: got err=%b done=%b want 1/0", errm, donem); end
        total++; if (crm !== 1'b0 || ifm.byte_ready !== 1'b0) begin bad++; $display("FAIL bad_rst_ready: got %b/%b want 0/0", crm, ifm.byte_ready); end
        total++; if (qa_m.size() != 2) begin bad++; $display("FAIL bad_nwrites: got %0d want 2", qa_m.size()); end
    endtask

    task automatic test_zero_len();
        do_reset();
        for (int i = 0; i < 5; i++) send(1'b0, 8'h00);
        idle();
        total++; if (donem !== 1'b1 || crm !== 1'b1) begin bad++; $display("FAIL zero_done: got %b/%b want 1/1", donem, crm); end
        total++; if (wlm !== 32'd0 || qa_m.size() != 0) begin bad++; $display("FAIL zero_writes: got words=%0d writes=%0d want 0/0", wlm, qa_m.size()); end
    endtask

    task automatic test_over_len();
        do_reset();
        send(1'b0, 8'h01); send(1'b0, 8'h04); send(1'b0, 8'h00); send(1'b0, 8'h00);
        idle();
        total++; if (errm !== 1'b1 || ifm.byte_ready !== 1'b0) begin bad++; $display("FAIL over_err: got err=%b ready=%b want 1/0", errm, ifm.byte_ready); end
        for (int i = 0; i < 4; i++) send(1'b0, 8'hAA);
        idle();
        total++; if (qa_m.size() != 0) begin bad++; $display("FAIL over_nowrite: got %0d want 0", qa_m.size()); end
        // start pulse with a simultaneous byte that must not be taken
        @(negedge clk);
        start = 1'b1; ifm.byte_valid = 1'b1; ifm.byte_data = 8'h55;
        @(negedge clk);
        start = 1'b0; ifm.byte_valid = 1'b0;
        total++; if (errm !== 1'b0 || ifm.byte_ready !== 1'b1 || wlm !== 32'd0) begin bad++; $display("FAIL over_restart: got err=%b ready=%b words=%0d want 0/1/0", errm, ifm.byte_ready, wlm); end
        send_body(1'b0);
        send(1'b0, 8'h90);
        idle();
        total++; if (donem !== 1'b1 || qa_m.size() != 2) begin bad++; $display("FAIL over_reload: got done=%b writes=%0d want 1/2", donem, qa_m.size()); end
        total++; if (qa_m[0] !== 30'd0 || qd_m[1] !== 32'h0010_0093) begin bad++; $display("FAIL over_reload_data: got %h/%h want 0/00100093", qa_m[0], qd_m[1]); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        stalls = 0;
        send_body(1'b1);
        send(1'b1, 8'h90);
        idle();
        total++; if (stalls != 0) begin bad++; $display("FAIL b2b_stalls: got %0d want 0", stalls); end
        total++; if (qa_w.size() != 2) begin bad++; $display("FAIL b2b_nwrites: got %0d want 2", qa_w.size()); end
        total++; if (qa_w[0] !== 30'h3FFF_FFFF || qd_w[0] !== 32'h0000_0013) begin bad++; $display("FAIL b2b_w0: got %h/%h want 3fffffff/00000013", qa_w[0], qd_w[0]); end
        total++; if (qa_w[1] !== 30'h0 || qd_w[1] !== 32'h0010_0093) begin bad++; $display("FAIL b2b_wrap: got %h/%h want 0/00100093", qa_w[1], qd_w[1]); end
        total++; if (donew !== 1'b1 || wlw !== 32'd2) begin bad++; $display("FAIL b2b_done: got %b/%0d want 1/2", donew, wlw); end
    endtask

    task automatic test_reset_midload();
        logic [7:0] pre [10];
        do_reset();
        pre = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00};
        for (int i = 0; i < 10; i++) send(1'b0, pre[i]);
        @(negedge clk);
        ifm.byte_valid = 1'b0;
        total++; if (wlm !== 32'd1) begin bad++; $display("FAIL mid_pre_words: got %0d want 1", wlm); end
        rst_n = 1'b0;
        #1;
        total++; if (wlm !== 32'd0 || ifm.imem_we !== 1'b0 || ifm.byte_ready !== 1'b1) begin bad++; $display("FAIL mid_async: got words=%0d we=%b ready=%b want 0/0/1", wlm, ifm.imem_we, ifm.byte_ready); end
        total++; if (ifm.imem_waddr !== 30'h0 || ifm.imem_wdata !== 32'h0 || {crm, donem, errm} !== 3'b000) begin bad++; $display("FAIL mid_async_bus: got %h/%h/%b want 0/0/000", ifm.imem_waddr, ifm.imem_wdata, {crm, donem, errm}); end
        @(negedge clk);
        rst_n = 1'b1;
        qa_m.delete(); qd_m.delete();
        send_body(1'b0);
        send(1'b0, 8'h90);
        idle();
        total++; if (qa_m.size() != 2 || donem !== 1'b1) begin bad++; $display("FAIL mid_reload: got writes=%0d done=%b want 2/1", qa_m.size(), donem); end
        total++; if (qa_m[0] !== 30'd0 || qd_m[0] !== 32'h0000_0013) begin bad++; $display("FAIL mid_reload_w0: got %h/%h want 0/00000013", qa_m[0], qd_m[0]); end
        total++; if (qa_m[1] !== 30'd1 || qd_m[1] !== 32'h0010_0093) begin bad++; $display("FAIL mid_reload_w1: got %h/%h want 1/00100093", qa_m[1], qd_m[1]); end
    endtask

    initial begin
        ifm.byte_valid = 1'b0; ifm.byte_data = 8'h00;
        ifw.byte_valid = 1'b0; ifw.byte_data = 8'h00;
        test_reset();
        test_load_ok();
        test_bad_csum();
        test_zero_len();
        test_over_len();
        test_back_to_back();
        test_reset_midload();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
